// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
// State encoding for the lock FSM lives here so benches can name states.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 16;
    localparam int LOCK_MAX_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to
// the port that was not granted most recently.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick0,
    output logic pick1
);

    always_comb begin
        pick0 = req0 & (~req1 | last);
        pick1 = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with round-robin ties and bounded bus locking.
// Grants are combinational; read-valid is registered one cycle behind.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             rr0;
    logic             rr1;
    logic             lock_done;

    rr_arbiter2 u_rr (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .pick0 (rr0),
        .pick1 (rr1)
    );

    assign lock_done = (cnt == CNT_MAX);

    // While reset is high the arbiter looks as if nobody is requesting.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    gnt0 = rr0;
                    gnt1 = rr1;
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
        end
    end

    assign rdata = (rvalid0 | rvalid1) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0) begin
                last <= 1'b0;
            end else if (gnt1) begin
                last <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (gnt0 && lock0) begin
                        state <= LOCK0;
                        cnt   <= CNT_ONE;
                    end else if (gnt1 && lock1) begin
                        state <= LOCK1;
                        cnt   <= CNT_ONE;
                    end
                end
                LOCK0: begin
                    if (!lock0 || lock_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                LOCK1: begin
                    if (!lock1 || lock_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, lock0;
    logic [11:0] addr0;
    logic [15:0] wdata0;
    logic        req1, we1, lock1;
    logic [11:0] addr1;
    logic [15:0] wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    int vecs = 0;
    int errs = 0;

    mem_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (16),
        .LOCK_MAX (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .lock0     (lock0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .lock1     (lock1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mval(input logic [11:0] a);
        return 16'hC000 ^ {a, 4'h5};
    endfunction

    // Memory remembers only the most recent write; everything else is mval.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid <= 1'b0;
        end else if (mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
        mem_rdata <= (wr_valid && wr_addr == mem_addr) ? wr_data : mval(mem_addr);
    end

    task automatic drive0(input logic r, input logic w, input logic l,
                          input logic [11:0] a, input logic [15:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l,
                          input logic [11:0] a, input logic [15:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic idle_in();
        drive0(0, 0, 0, 12'h000, 16'h0000);
        drive1(0, 0, 0, 12'h000, 16'h0000);
    endtask

    task automatic test_reset();
        drive0(1, 0, 0, 12'h123, 16'h1111);
        drive1(1, 1, 0, 12'h456, 16'h2222);
        #1;
        vecs++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errs++; $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1});
        end
        vecs++;
        if ({mem_we, mem_addr, mem_wdata} !== 29'd0) begin
            errs++; $display("FAIL rst_mem: got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_wdata);
        end
        vecs++;
        if ({rvalid0, rvalid1, rdata} !== 18'd0) begin
            errs++; $display("FAIL rst_rvalid: got %b%b %h want 00 0000", rvalid0, rvalid1, rdata);
        end
        idle_in();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_tie();
        drive0(1, 0, 0, 12'h010, 16'h0);
        drive1(1, 0, 0, 12'h020, 16'h0);
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_addr} !== {2'b10, 12'h010}) begin
            errs++; $display("FAIL tie_first: got g=%b%b a=%h want 10 010", gnt0, gnt1, mem_addr);
        end
        @(negedge clk);
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_addr} !== {2'b01, 12'h020}) begin
            errs++; $display("FAIL tie_second: got g=%b%b a=%h want 01 020", gnt0, gnt1, mem_addr);
        end
        vecs++;
        if ({rvalid0, rvalid1, rdata} !== {2'b10, mval(12'h010)}) begin
            errs++; $display("FAIL tie_rd0: got %b%b %h want 10 %h", rvalid0, rvalid1, rdata, mval(12'h010));
        end
        @(negedge clk);
        idle_in();
        #1;
        vecs++;
        if ({gnt0, gnt1, rvalid0, rvalid1, rdata} !== {4'b0001, mval(12'h020)}) begin
            errs++; $display("FAIL tie_rd1: got g=%b%b v=%b%b %h want 0001 %h",
                             gnt0, gnt1, rvalid0, rvalid1, rdata, mval(12'h020));
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        drive0(1, 1, 0, 12'h0FF, 16'hBEEF);
        #1;
        vecs++;
        if ({gnt0, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h0FF, 16'hBEEF}) begin
            errs++; $display("FAIL wr_cmd: got g=%b we=%b a=%h d=%h want 1 1 0ff beef",
                             gnt0, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        drive0(0, 0, 0, 12'h000, 16'h0);
        drive1(1, 0, 0, 12'h0FF, 16'h0);
        #1;
        vecs++;
        if ({rvalid0, gnt1, mem_we} !== 3'b010) begin
            errs++; $display("FAIL wr_no_rvalid: got v0=%b g1=%b we=%b want 0 1 0", rvalid0, gnt1, mem_we);
        end
        @(negedge clk);
        idle_in();
        #1;
        vecs++;
        if ({rvalid1, rdata} !== {1'b1, 16'hBEEF}) begin
            errs++; $display("FAIL wr_readback: got v1=%b %h want 1 beef", rvalid1, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_lock0();
        drive0(1, 0, 1, 12'h100, 16'h0);
        drive1(1, 0, 0, 12'h020, 16'h0);
        #1;
        vecs++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errs++; $display("FAIL lk_c1: got %b%b want 10", gnt0, gnt1);
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            drive0(1, 0, (i == 1), 12'h100 + 12'(i), 16'h0);
            #1;
            vecs++;
            if ({gnt0, gnt1, rvalid0, rdata} !== {3'b101, mval(12'h100 + 12'(i - 1))}) begin
                errs++; $display("FAIL lk_c%0d: got g=%b%b v0=%b %h want 101 %h",
                                 i + 1, gnt0, gnt1, rvalid0, rdata, mval(12'h100 + 12'(i - 1)));
            end
        end
        @(negedge clk);
        #1;
        vecs++;
        if ({gnt0, gnt1, rvalid0, rdata} !== {3'b011, mval(12'h102)}) begin
            errs++; $display("FAIL lk_release: got g=%b%b v0=%b %h want 011 %h",
                             gnt0, gnt1, rvalid0, rdata, mval(12'h102));
        end
        @(negedge clk);
        idle_in();
        #1;
        vecs++;
        if ({rvalid1, rdata} !== {1'b1, mval(12'h020)}) begin
            errs++; $display("FAIL lk_rd1: got v1=%b %h want 1 %h", rvalid1, rdata, mval(12'h020));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive0(1, 0, 0, 12'h200 + 12'(i), 16'h0);
            else idle_in();
            #1;
            if (i < 4) begin
                vecs++;
                if ({gnt0, mem_addr} !== {1'b1, 12'h200 + 12'(i)}) begin
                    errs++; $display("FAIL b2b_gnt%0d: got g0=%b a=%h want 1 %h",
                                     i, gnt0, mem_addr, 12'h200 + 12'(i));
                end
            end
            if (i > 0) begin
                vecs++;
                if ({rvalid0, rdata} !== {1'b1, mval(12'h200 + 12'(i - 1))}) begin
                    errs++; $display("FAIL b2b_rd%0d: got v0=%b %h want 1 %h",
                                     i, rvalid0, rdata, mval(12'h200 + 12'(i - 1)));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock_timeout();
        drive1(1, 1, 1, 12'h300, 16'h0);
        #1;
        vecs++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errs++; $display("FAIL to_enter: got %b%b want 01", gnt0, gnt1);
        end
        @(negedge clk);
        drive0(1, 0, 0, 12'h040, 16'h0);
        for (int k = 1; k <= 15; k++) begin
            wdata1 = 16'(k);
            #1;
            vecs++;
            if ({gnt0, gnt1} !== 2'b01) begin
                errs++; $display("FAIL to_hold%0d: got %b%b want 01", k, gnt0, gnt1);
            end
            @(negedge clk);
        end
        #1;
        vecs++;
        if ({gnt0, gnt1, mem_addr} !== {2'b10, 12'h040}) begin
            errs++; $display("FAIL to_release: got g=%b%b a=%h want 10 040", gnt0, gnt1, mem_addr);
        end
        @(negedge clk);
        idle_in();
        #1;
        vecs++;
        if ({rvalid0, rdata} !== {1'b1, mval(12'h040)}) begin
            errs++; $display("FAIL to_rd0: got v0=%b %h want 1 %h", rvalid0, rdata, mval(12'h040));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_lock();
        drive0(1, 0, 1, 12'h030, 16'h0);
        #1;
        vecs++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errs++; $display("FAIL ril_enter: got %b%b want 10", gnt0, gnt1);
        end
        @(negedge clk);
        addr0 = 12'h031;
        #1;
        vecs++;
        if ({gnt0, rvalid0, rdata} !== {2'b11, mval(12'h030)}) begin
            errs++; $display("FAIL ril_pre: got g0=%b v0=%b %h want 11 %h", gnt0, rvalid0, rdata, mval(12'h030));
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({gnt0, rvalid0, rdata, mem_addr} !== 30'd0) begin
            errs++; $display("FAIL ril_drop: got g0=%b v0=%b %h a=%h want 0", gnt0, rvalid0, rdata, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        drive0(1, 0, 0, 12'h032, 16'h0);
        drive1(1, 0, 0, 12'h033, 16'h0);
        #1;
        vecs++;
        if ({gnt0, gnt1, rvalid0} !== 3'b100) begin
            errs++; $display("FAIL ril_tie: got g=%b%b v0=%b want 100", gnt0, gnt1, rvalid0);
        end
        @(negedge clk);
        #1;
        vecs++;
        if ({gnt0, gnt1, rvalid0, rdata} !== {3'b011, mval(12'h032)}) begin
            errs++; $display("FAIL ril_rr: got g=%b%b v0=%b %h want 011 %h",
                             gnt0, gnt1, rvalid0, rdata, mval(12'h032));
        end
        @(negedge clk);
        idle_in();
        #1;
        vecs++;
        if ({rvalid1, rdata} !== {1'b1, mval(12'h033)}) begin
            errs++; $display("FAIL ril_rd1: got v1=%b %h want 1 %h", rvalid1, rdata, mval(12'h033));
        end
        @(negedge clk);
    endtask

    task automatic test_idle();
        idle_in();
        for (int i = 0; i < 10; i++) begin
            #1;
            vecs++;
            if ({gnt0, gnt1, mem_we, mem_addr, mem_wdata} !== 31'd0) begin
                errs++; $display("FAIL idle_mem%0d: got g=%b%b we=%b a=%h d=%h want 0",
                                 i, gnt0, gnt1, mem_we, mem_addr, mem_wdata);
            end
            vecs++;
            if ({rvalid0, rvalid1, rdata} !== 18'd0) begin
                errs++; $display("FAIL idle_rv%0d: got %b%b %h want 00 0000", i, rvalid0, rvalid1, rdata);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        repeat (2) @(negedge clk);
        test_reset();
        test_tie();
        test_write();
        test_lock0();
        test_back_to_back();
        test_lock_timeout();
        test_reset_in_lock();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter LOCK_MAX, default 15, maximum cycles a locked owner holds memory after its first grant.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req0/req1  in  1  access request, port 0 (CPU) / port 1 (loader/DMA).
REQ-007 we0/we1  in  1  1 = write, 0 = read, qualified by reqN.
REQ-008 lock0/lock1  in  1  keep ownership after this access (multi-word sequences, e.g. two-word LDI fetch).
REQ-009 addr0/addr1  in  ADDR_W  access address.
REQ-010 wdata0/wdata1  in  DATA_W  write data.
REQ-011 gnt0/gnt1  out  1  access issued to memory this cycle.
REQ-012 rvalid0/rvalid1  out  1  read data valid on rdata this cycle.
REQ-013 rdata  out  DATA_W  read data, shared by both ports.
REQ-014 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_we  out  1  memory-side command.
REQ-015 mem_rdata  in  DATA_W  memory read data, valid one cycle after address.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high in any cycle; grant is combinational from state and requests.
REQ-017 States: IDLE, LOCK0, LOCK1.
REQ-018 IDLE: single requester granted; both requesting -> port != last, where last = most recently granted port.
REQ-019 On any grant, last SHALL take the granted port number.
REQ-020 IDLE, grant to N with lockN=1 -> LOCKN, lock counter loads 1; lockN=0 -> stay IDLE.
REQ-021 LOCKN: only port N grantable; gntN = reqN; other port's requests stall without grant.
REQ-022 LOCKN exits to IDLE on: (reqN & ~lockN) after that grant, or (~reqN & ~lockN), or counter == LOCK_MAX.
REQ-023 Lock counter increments every cycle in LOCKN, saturating at LOCK_MAX; forced exit SHALL leave last = N so a waiting other port wins next.
REQ-024 Granted port drives mem_addr/mem_wdata; mem_we = gnt & we of that port; no grant -> mem_addr = 0, mem_wdata = 0, mem_we = 0.
REQ-025 Read granted in cycle T -> rvalidN high in T+1 only, rdata = mem_rdata; rdata = 0 when no rvalid.
REQ-026 Writes SHALL produce no rvalid; back-to-back grants (one per cycle) SHALL be supported with no bubble.

Reset
REQ-027 rst high -> state IDLE, last = 1 (port 0 wins first tie), counter 0, rvalid0/rvalid1 = 0, immediately and asynchronously.
REQ-028 Reset during LOCKN or with a read in flight SHALL drop that read's rvalid; gnt/mem outputs follow the zero-request form while rst is high.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum (IDLE, LOCK0, LOCK1) and default ADDR_W/DATA_W/LOCK_MAX constants.
REQ-030 One sub-module, rr_arbiter2 (2-way round-robin pick with last pointer), SHALL be instantiated; lock FSM, counter and muxing stay in mem_arbiter.

Verification
REQ-031 After reset, req0=req1=1 reads addr0=0x010, addr1=0x020 for 2 cycles -> gnt0 then gnt1, rvalid0 then rvalid1 one cycle later with memory contents.
REQ-032 req0 write we0=1 addr0=0x0FF wdata0=0xBEEF -> mem_we=1, mem_addr=0x0FF, mem_wdata=0xBEEF same cycle, no rvalid0.
REQ-033 port 0 lock0=1 for 3 reads while req1=1 -> gnt1 low throughout; lock0 drops on the 3rd -> gnt1 next cycle.
REQ-034 port 1 holds lock1=1 and req1=1 indefinitely with req0=1 -> forced release after 15 cycles in LOCK1, gnt0 next cycle.
REQ-035 rst asserted mid-cycle during a read in LOCK0 -> state IDLE, rvalid0 low at once, next tie goes to port 0.
REQ-036 No requests for 10 cycles -> mem_we=0, mem_addr=0, no gnt, no rvalid.
